// File: rtl/obj_line_buffer.sv
// obj_line_buffer: ping-pong sprite line buffer.
// The sprite engine draws the next line into the write bank (bsel).
// At the same time, the current line streams out of the read bank (~bsel)
// on each pixel enable. When clear-after-read is on, every pixel that is
// read is zeroed one MCLK later. After reset, an INIT sweep zeroes both
// banks before the block accepts any writes.
//
// Optional feature: define OBJ_FIRST_WINS_EN to make the first opaque pixel
// win. Each write then becomes a read-before-write: the write lands one MCLK
// after it is accepted, and o_WR_READY drops for that cycle.
//
// Ports:
//   i_MCLK, i_MRST_n   master clock, async active-low reset
//   i_6MPOSCEN_n       pixel enable (active low, one MCLK wide)
//   i_OBJBUFMUX        bank select, registered into bsel every MCLK
//   i_OBJBUFCLR        clear-after-read enable, sampled at capture
//   i_HCNTR            read address
//   i_WR_EN/X/PX       sprite engine write port
//   o_WR_READY         writes accepted
//   o_OBJ_PX           pixel to the mixer, 2 MCLK after the pixel enable
//   o_OBJ_OPAQUE       o_OBJ_PX colour index != 0
module obj_line_buffer #(
  parameter int PXW = 8,
  parameter int XW  = 9
) (
  input  logic           i_MCLK,
  input  logic           i_MRST_n,
  input  logic           i_6MPOSCEN_n,
  input  logic           i_OBJBUFMUX,
  input  logic           i_OBJBUFCLR,
  input  logic [XW-1:0]  i_HCNTR,
  input  logic           i_WR_EN,
  input  logic [XW-1:0]  i_WR_X,
  input  logic [PXW-1:0] i_WR_PX,
  output logic           o_WR_READY,
  output logic [PXW-1:0] o_OBJ_PX,
  output logic           o_OBJ_OPAQUE
);

  localparam int DEPTH = 1 << XW;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   sweep, sweep_nxt;
  logic            bsel;
  logic            run;
  logic            pen;

  logic [PXW-1:0]  mem [2][DEPTH];

  // capture stage
  logic            cap_vld;
  logic [PXW-1:0]  cap_px;
  logic            clr_pend;
  logic            clr_bank;
  logic [XW-1:0]   clr_addr;
  logic            clr_hit;

  // resolved write port
  logic            wr_do;
  logic            wr_b;
  logic [XW-1:0]   wr_a;
  logic [PXW-1:0]  wr_d;

  // ---------------- FSM ----------------
  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    case (state)
      INIT: begin
        sweep_nxt = sweep + 1'b1;
        if (sweep == XW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  assign run = (state == RUN);
  assign pen = run & ~i_6MPOSCEN_n;

  // ---------------- bank select ----------------
  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) bsel <= 1'b0;
    else           bsel <= i_OBJBUFMUX;
  end

  // ---------------- write port ----------------
`ifdef OBJ_FIRST_WINS_EN
  logic            wr_busy;
  logic            wr_bank;
  logic [XW-1:0]   wr_x;
  logic [PXW-1:0]  wr_px;
  logic            wr_acc;

  assign wr_acc = run & i_WR_EN & ~wr_busy;

  // Latch the request together with the bank it was aimed at. A swap in
  // the landing cycle does not redirect it.
  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      wr_busy <= 1'b0;
      wr_bank <= 1'b0;
      wr_x    <= '0;
      wr_px   <= '0;
    end else begin
      wr_busy <= wr_acc;
      if (wr_acc) begin
        wr_bank <= bsel;
        wr_x    <= i_WR_X;
        wr_px   <= i_WR_PX;
      end
    end
  end

  assign wr_do = wr_busy && (wr_px[3:0] != 4'd0) && (mem[wr_bank][wr_x][3:0] == 4'd0);
  assign wr_b  = wr_bank;
  assign wr_a  = wr_x;
  assign wr_d  = wr_px;
  assign o_WR_READY = run & ~wr_busy;
`else
  assign wr_do = run & i_WR_EN & (i_WR_PX[3:0] != 4'd0);
  assign wr_b  = bsel;
  assign wr_a  = i_WR_X;
  assign wr_d  = i_WR_PX;
  assign o_WR_READY = run;
`endif

  // ---------------- read / clear pipeline ----------------
  // A pending clear has not reached the array yet. If back-to-back enables
  // hit the same entry, return the cleared value instead of the stale one.
  assign clr_hit = clr_pend && (clr_bank == ~bsel) && (clr_addr == i_HCNTR);

  always_ff @(posedge i_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      cap_vld      <= 1'b0;
      cap_px       <= '0;
      clr_pend     <= 1'b0;
      clr_bank     <= 1'b0;
      clr_addr     <= '0;
      o_OBJ_PX     <= '0;
      o_OBJ_OPAQUE <= 1'b0;
    end else begin
      cap_vld  <= pen;
      clr_pend <= pen & i_OBJBUFCLR;
      if (pen) begin
        cap_px   <= clr_hit ? '0 : mem[~bsel][i_HCNTR];
        clr_bank <= ~bsel;
        clr_addr <= i_HCNTR;
      end
      if (cap_vld) begin
        o_OBJ_PX     <= cap_px;
        o_OBJ_OPAQUE <= |cap_px[3:0];
      end
    end
  end

  // ---------------- storage ----------------
  // The clear is issued after the write, so it wins the single entry where
  // both meet across a bank swap.
  always_ff @(posedge i_MCLK) begin
    if (!run) begin
      mem[0][sweep] <= '0;
      mem[1][sweep] <= '0;
    end else begin
      if (wr_do)    mem[wr_b][wr_a]         <= wr_d;
      if (clr_pend) mem[clr_bank][clr_addr] <= '0;
    end
  end

endmodule

// File: tb/tb_obj_line_buffer.sv
module tb_obj_line_buffer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pen_n = 1'b1;
  logic       mux = 1'b0;
  logic       clr = 1'b0;
  logic [8:0] hcntr = '0;
  logic       wr_en = 1'b0;
  logic [8:0] wr_x = '0;
  logic [7:0] wr_px = '0;
  logic       rdy;
  logic [7:0] opx;
  logic       opq;

  int checks = 0;
  int errors = 0;
  bit go = 0;

  obj_line_buffer #(.PXW(8), .XW(9)) dut (
    .i_MCLK(clk), .i_MRST_n(rst_n), .i_6MPOSCEN_n(pen_n), .i_OBJBUFMUX(mux),
    .i_OBJBUFCLR(clr), .i_HCNTR(hcntr), .i_WR_EN(wr_en), .i_WR_X(wr_x),
    .i_WR_PX(wr_px), .o_WR_READY(rdy), .o_OBJ_PX(opx), .o_OBJ_OPAQUE(opq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Line contents as plain arrays. Each enable picks a value from the read
  // bank. That value is shown two edges later. The entry is zeroed one edge
  // later, and a zero pending on that same entry counts as already done.
  logic [7:0] mm [2][512];
  logic       mb = 0;
  int         mcyc = 0;
  logic       due_v = 0;
  logic [7:0] due_px = 0;
  logic       zap_p = 0, zap_b = 0;
  logic [8:0] zap_a = 0;
  logic [7:0] m_rd;
  logic [7:0] e_px = 0;
  logic       e_rdy = 0;
  logic       hold = 0, hold_b = 0, acc;
  logic [8:0] hold_x = 0;
  logic [7:0] hold_d = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) for (int a = 0; a < 512; a++) mm[b][a] = 8'h00;
      mb = 0; mcyc = 0; due_v = 0; due_px = 0; zap_p = 0; zap_b = 0; zap_a = 0;
      e_px = 0; e_rdy = 0; hold = 0; hold_b = 0; hold_x = 0; hold_d = 0;
    end else begin
      if (mcyc >= 512) begin
        if (due_v) e_px = due_px;
        m_rd = (zap_p && zap_b == !mb && zap_a == hcntr) ? 8'h00 : mm[!mb][hcntr];
`ifdef OBJ_FIRST_WINS_EN
        if (hold && hold_d[3:0] != 0 && mm[hold_b][hold_x][3:0] == 0) mm[hold_b][hold_x] = hold_d;
        acc = wr_en && !hold;
        hold = acc;
        if (acc) begin hold_b = mb; hold_x = wr_x; hold_d = wr_px; end
`else
        if (wr_en && wr_px[3:0] != 0) mm[mb][wr_x] = wr_px;
`endif
        if (zap_p) mm[zap_b][zap_a] = 8'h00;
        due_v = !pen_n;
        zap_p = !pen_n && clr;
        if (!pen_n) begin due_px = m_rd; zap_b = !mb; zap_a = hcntr; end
      end
      mb = mux;
      if (mcyc < 1000000) mcyc++;
      e_rdy = (mcyc >= 512) && !hold;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("model_ready", {31'd0, rdy}, {31'd0, e_rdy});
      chk("model_px", {24'd0, opx}, {24'd0, e_px});
      chk("model_opaque", {31'd0, opq}, {31'd0, |e_px[3:0]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_mux(input logic v);
    @(posedge clk); #2 mux = v;
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [8:0] x, input logic [7:0] px);
    @(posedge clk); #2 wr_en = 1; wr_x = x; wr_px = px;
    @(posedge clk); #2 wr_en = 0;
    @(posedge clk); #2;
  endtask

  task automatic rd(input logic [8:0] h, input logic c, output logic [7:0] v, output logic o);
    @(posedge clk); #2 pen_n = 0; hcntr = h; clr = c;
    @(posedge clk); #2 pen_n = 1; clr = 0;
    @(posedge clk); @(negedge clk); v = opx; o = opq;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); @(negedge clk);
      if (rdy) begin n = i; wr_en = 0; break; end
    end
    if (n < 0) begin
      errors++;
      $display("FAIL wait_ready: ready never rose within 2000 cycles");
    end
  endtask

  logic [7:0] v;
  logic       o;
  int         n;

  initial begin
    #1 rst_n = 0;
    #1 go = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_px", {24'd0, opx}, 32'h0);
    chk("reset_ready", {31'd0, rdy}, 32'h0);

    // Test 1: sweep length, and writes held during INIT are ignored
    @(posedge clk); #2 rst_n = 1; wr_en = 1; wr_x = 9'h010; wr_px = 8'h35;
    pen_n = 0; hcntr = 9'h010;
    wait_ready(n);
    pen_n = 1;
    chk("init_cycles", n, 512);
    rd(9'h010, 0, v, o); chk("init_read_b1", {24'd0, v}, 32'h00);
    set_mux(1);
    rd(9'h010, 0, v, o); chk("init_read_b0", {24'd0, v}, 32'h00);

    // Test 2 and 3: write, swap, read with clear
    set_mux(0);
    wr(9'h010, 8'h35);
    set_mux(1);
    rd(9'h010, 1, v, o); chk("rd_clr_first", {24'd0, v}, 32'h35); chk("rd_opaque", {31'd0, o}, 32'h1);
    rd(9'h010, 1, v, o); chk("rd_clr_second", {24'd0, v}, 32'h00); chk("rd_transp", {31'd0, o}, 32'h0);
    set_mux(0);
    wr(9'h010, 8'h35);
    set_mux(1);
    rd(9'h010, 0, v, o); chk("rd_noclr_first", {24'd0, v}, 32'h35);
    rd(9'h010, 0, v, o); chk("rd_noclr_second", {24'd0, v}, 32'h35);

    // Test 4: transparent write is suppressed; overwrite policy
    set_mux(0);
    wr(9'h010, 8'h70);
    set_mux(1);
    rd(9'h010, 0, v, o); chk("transp_write", {24'd0, v}, 32'h35);
    set_mux(0);
    wr(9'h010, 8'h42);
    set_mux(1);
`ifdef OBJ_FIRST_WINS_EN
    rd(9'h010, 0, v, o); chk("overwrite", {24'd0, v}, 32'h35);
`else
    rd(9'h010, 0, v, o); chk("overwrite", {24'd0, v}, 32'h42);
`endif

    // Test 5: address extremes do not alias
    set_mux(0);
    wr(9'h1FF, 8'h5A);
    wr(9'h000, 8'hA3);
    set_mux(1);
    rd(9'h1FF, 1, v, o); chk("addr_top", {24'd0, v}, 32'h5A);
    rd(9'h000, 1, v, o); chk("addr_zero", {24'd0, v}, 32'hA3);

    // A write in the same cycle as a toggle goes to the old bank (bank 0)
    set_mux(0);
    @(posedge clk); #2 mux = 1; wr_en = 1; wr_x = 9'h020; wr_px = 8'h19;
    @(posedge clk); #2 wr_en = 0;
    @(posedge clk); #2;
    rd(9'h020, 1, v, o); chk("swap_edge_write", {24'd0, v}, 32'h19);

    // Randomized traffic, with a reset in the middle
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      wr_en = 1'($urandom_range(0, 1));
      wr_x  = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
      wr_px = 8'($urandom);
      hcntr = 9'($urandom_range(0, 15));
      pen_n = ($urandom_range(0, 2) != 0);
      clr   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) mux = ~mux;
      if (i == 1500) rst_n = 0;
      if (i == 1503) rst_n = 1;
    end
    @(posedge clk); #2 pen_n = 1; wr_en = 0; clr = 0;

    // Test 6: reset mid-operation clears everything
    set_mux(0);
    wr(9'h010, 8'h35);
    set_mux(1);
    wr(9'h1FF, 8'h66);
    @(posedge clk); #2 rst_n = 0;
    @(negedge clk);
    chk("midrst_px", {24'd0, opx}, 32'h0);
    chk("midrst_ready", {31'd0, rdy}, 32'h0);
    @(posedge clk); #2 rst_n = 1; mux = 0;
    wait_ready(n);
    chk("midrst_init_cycles", n, 512);
    set_mux(1);
    rd(9'h010, 0, v, o); chk("midrst_old_b0", {24'd0, v}, 32'h00);
    set_mux(0);
    rd(9'h1FF, 0, v, o); chk("midrst_old_b1", {24'd0, v}, 32'h00);

    repeat (4) @(posedge clk);
    @(negedge clk);
    go = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
